// File: rtl/clken_phase_divider_if.sv
// Signal bundle between the timing controller side and clken_phase_divider.
// Master drives the tick enable and hold; slave (the divider) drives the phase outputs.
interface clken_phase_divider_if #(
   parameter int unsigned DIVIDER    = 12,
   parameter int unsigned DEBT_WIDTH = 4
);
   localparam int unsigned PW = $clog2(DIVIDER);

   logic                  ClkEnIn;
   logic                  Hold;
   logic                  CycleEn;
   logic                  Phi2;
   logic [PW-1:0]         PhaseCount;
   logic [DEBT_WIDTH-1:0] Debt;
   logic                  CatchupReq;
   logic                  Overrun;

   modport master (
      output ClkEnIn, Hold,
      input  CycleEn, Phi2, PhaseCount, Debt, CatchupReq, Overrun
   );

   modport slave (
      input  ClkEnIn, Hold,
      output CycleEn, Phi2, PhaseCount, Debt, CatchupReq, Overrun
   );
endinterface

// File: rtl/clken_phase_divider.sv
// Divides the master-tick enable into a CPU-cycle pulse and Phi2 level, banking held-off cycles.
// Define CLKEN_PHASE_DIVIDER_CATCHUP_EN to enable debt banking and idle-clock catch-up.
module clken_phase_divider #(
   parameter int unsigned DIVIDER    = 12,
   parameter int unsigned PHI_SPLIT  = 6,
   parameter int unsigned DEBT_WIDTH = 4
) (
   input  logic                   Clk,
   input  logic                   Reset,
   clken_phase_divider_if.slave   bus
);
   localparam int unsigned   PW    = $clog2(DIVIDER);
   localparam logic [PW-1:0] LAST  = PW'(DIVIDER - 1);
   localparam logic [PW-1:0] SPLIT = PW'(PHI_SPLIT);

   logic [PW-1:0] phase_q, phase_nxt;
   logic          cycle_q, cycle_nxt;
   logic          phi2_q;
   logic          overrun_q, overrun_nxt;
   logic          boundary;

   assign boundary = bus.ClkEnIn && (phase_q == LAST);

   always_comb begin
      phase_nxt = phase_q;
      if (bus.ClkEnIn) begin
         phase_nxt = boundary ? '0 : phase_q + PW'(1);
      end
   end

`ifdef CLKEN_PHASE_DIVIDER_CATCHUP_EN
   localparam logic [DEBT_WIDTH-1:0] DEBT_MAX = '1;

   logic [DEBT_WIDTH-1:0] debt_q, debt_nxt;
   logic                  catchup_q;

   // A boundary always wins over repayment; catch-up only uses idle, unheld clocks.
   always_comb begin
      cycle_nxt   = 1'b0;
      overrun_nxt = overrun_q;
      debt_nxt    = debt_q;
      if (boundary && bus.Hold) begin
         if (debt_q != DEBT_MAX) begin
            debt_nxt = debt_q + DEBT_WIDTH'(1);
         end else begin
            overrun_nxt = 1'b1;
         end
      end else if (boundary) begin
         cycle_nxt = 1'b1;
      end else if (!bus.Hold && !bus.ClkEnIn && (debt_q != '0)) begin
         cycle_nxt = 1'b1;
         debt_nxt  = debt_q - DEBT_WIDTH'(1);
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         debt_q    <= '0;
         catchup_q <= 1'b0;
      end else begin
         debt_q    <= debt_nxt;
         catchup_q <= (debt_nxt != '0);
      end
   end

   assign bus.Debt       = debt_q;
   assign bus.CatchupReq = catchup_q;
`else
   always_comb begin
      cycle_nxt   = 1'b0;
      overrun_nxt = overrun_q;
      if (boundary && bus.Hold) begin
         overrun_nxt = 1'b1;
      end else if (boundary) begin
         cycle_nxt = 1'b1;
      end
   end

   assign bus.Debt       = {DEBT_WIDTH{1'b0}};
   assign bus.CatchupReq = 1'b0;
`endif

   always_ff @(posedge Clk) begin
      if (Reset) begin
         phase_q   <= '0;
         cycle_q   <= 1'b0;
         phi2_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         phase_q   <= phase_nxt;
         cycle_q   <= cycle_nxt;
         phi2_q    <= (phase_nxt >= SPLIT);
         overrun_q <= overrun_nxt;
      end
   end

   assign bus.PhaseCount = phase_q;
   assign bus.CycleEn    = cycle_q;
   assign bus.Phi2       = phi2_q;
   assign bus.Overrun    = overrun_q;
endmodule
